rburst_master: RTL and testbench
================================

Name: rburst_master

Overview:
AXI4 read-burst initiator that fills the pixel read FIFO from the DDR frame buffer. It issues fixed-length INCR bursts whenever the FIFO reports room for a full burst, and pushes every returned beat into the FIFO. The read address walks linearly over one frame and wraps back to the frame base.

Parameters:
AW, 32, AXI address width
DATA_W, 64, AXI data width and FIFO entry width; power of two, >= 8
BURST_LEN, 16, beats per burst; 1..256
BASE_ADDR, 32'h1000_0000, frame buffer start; aligned to burst bytes
FRAME_BYTES, 32'h0020_0000, frame size; nonzero multiple of BURST_LEN*DATA_W/8

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
en_i  in  1  enable streaming; low in IDLE rewinds the address to BASE_ADDR
fifo_rdy_i  in  1  FIFO has room for at least BURST_LEN entries
fifo_incr_o  out  1  push strobe for one FIFO entry
fifo_data_o  out  DATA_W  data for the push
araddr_o  out  AW  AR address
arlen_o  out  8  constant BURST_LEN-1
arsize_o  out  3  constant log2(DATA_W/8)
arburst_o  out  2  constant 2'b01 (INCR)
arvalid_o  out  1  AR valid
arready_i  in  1  AR ready
rdata_i  in  DATA_W  R data
rresp_i  in  2  R response
rlast_i  in  1  R last
rvalid_i  in  1  R valid
rready_o  out  1  R ready
busy_o  out  1  state != IDLE
err_o  out  1  sticky error flag

Behaviour:
- Reset (async, rst_ni low): state=IDLE, addr=BASE_ADDR, beat count=0, err_o=0. arvalid_o, rready_o, fifo_incr_o and busy_o are all 0.
- FSM states: IDLE, ADDR, DATA.
- IDLE → ADDR when en_i & fifo_rdy_i, decided in the same cycle. The issue is blocked when err_o=1 and RBURST_ERR_HALT_EN is defined.
- IDLE with en_i=0: addr loads BASE_ADDR on the next edge.
- ADDR:
  - arvalid_o=1 with araddr_o=addr.
  - araddr_o stays stable and arvalid_o is never withdrawn until arready_i.
  - arvalid_o & arready_i → DATA, count=0.
- DATA:
  - rready_o=1 throughout. This is safe because fifo_rdy_i guaranteed the space.
  - Each rvalid_i & rready_o beat: fifo_incr_o=1 combinationally in the same cycle, fifo_data_o=rdata_i, count++.
  - fifo_incr_o=0 in every other cycle.
- Last beat (count==BURST_LEN-1):
  - addr += BURST_LEN*DATA_W/8.
  - If the result equals BASE_ADDR+FRAME_BYTES, addr=BASE_ADDR instead (frame wrap).
  - Next state is ADDR if en_i & fifo_rdy_i (back-to-back, no IDLE bubble), else IDLE.
- fifo_rdy_i is sampled only at burst issue. Deassertion during DATA does not stall R.
- en_i falling mid-burst: the burst always completes (AXI reads cannot be aborted), then the FSM goes to IDLE, then addr rewinds.
- Errors (err_o set on the next edge, sticky until reset):
  - rresp_i != 0 on any accepted beat.
  - rlast_i=1 on a beat other than count==BURST_LEN-1.
  - rlast_i=0 on the final beat.
- Data from error beats is still pushed, and the beat count is still driven by the fixed BURST_LEN.
- Only one outstanding burst at a time; AR is never issued during DATA.
- Address arithmetic is modulo 2^AW. The count register is 8 bits wide.

Optional Feature:
RBURST_ERR_HALT_EN:
- Defined: once err_o=1, the FSM completes the current burst, then stays in IDLE and issues no further AR until reset. busy_o falls.
- Undefined: err_o is a status flag only, and streaming continues normally.

Test Plan:
- Reset then en_i=1, fifo_rdy_i=1, arready_i=1 after 3 cycles:
  - araddr_o=32'h1000_0000 and arlen_o=15 are held stable for 3 cycles.
  - 16 R beats with rlast_i on beat 16 → 16 fifo_incr_o pulses carrying matching data.
  - Second AR at 32'h1000_0080, with no IDLE cycle in between.
- R beats with random rvalid_i gaps: fifo_incr_o pulses exactly on the valid cycles, the count stays correct, and 16 pushes occur per burst.
- FRAME_BYTES=256, DATA_W=64, BURST_LEN=16:
  - Addresses sequence 0x1000_0000, 0x1000_0080, then 0x1000_0000 (wrap).
- en_i dropped at beat 5:
  - Remaining 11 beats accepted, then IDLE with busy_o=0.
  - addr=BASE_ADDR on re-enable.
- rresp_i=2'b10 on beat 3, or rlast_i asserted on beat 10: err_o=1 from the next cycle and stays 1.
  - With RBURST_ERR_HALT_EN, no further arvalid_o after the burst.
  - Without it, the next AR issues normally.
- rst_ni pulsed low during DATA: all outputs drop to their reset values immediately, and addr returns to BASE_ADDR.

Source files
------------

// File: rtl/rburst_master.sv
// AXI4 read-burst initiator: issues fixed-length INCR bursts over one frame
// buffer and pushes every returned beat into the pixel read FIFO.
//
// Optional build macro: RBURST_ERR_HALT_EN
//   defined   - once err_o is set, the current burst completes and no
//               further AR is issued until reset
//   undefined - err_o is a status flag only
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   en_i                 enable streaming (low in IDLE rewinds address)
//   fifo_rdy_i           FIFO has room for a full burst
//   fifo_incr_o          FIFO push strobe (one per accepted R beat)
//   fifo_data_o          FIFO push data
//   araddr_o .. arvalid_o, arready_i   AXI AR channel
//   rdata_i .. rvalid_i, rready_o      AXI R channel
//   busy_o               FSM not in IDLE
//   err_o                sticky protocol/response error
module rburst_master #(
    parameter int unsigned    AW          = 32,
    parameter int unsigned    DATA_W      = 64,
    parameter int unsigned    BURST_LEN   = 16,
    parameter logic [AW-1:0]  BASE_ADDR   = AW'(32'h1000_0000),
    parameter logic [AW-1:0]  FRAME_BYTES = AW'(32'h0020_0000)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              fifo_rdy_i,
    output logic              fifo_incr_o,
    output logic [DATA_W-1:0] fifo_data_o,
    output logic [AW-1:0]     araddr_o,
    output logic [7:0]        arlen_o,
    output logic [2:0]        arsize_o,
    output logic [1:0]        arburst_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rlast_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam logic [AW-1:0] BURST_BYTES =
        AW'(BURST_LEN * (DATA_W / 8));
    localparam logic [AW-1:0] END_ADDR   = BASE_ADDR + FRAME_BYTES;
    localparam logic [7:0]    LAST_BEAT  = 8'(BURST_LEN - 1);
    localparam logic [2:0]    SIZE_CODE  = 3'($clog2(DATA_W / 8));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    count_q;
    logic          arvalid_q;
    logic          rready_q;
    logic          busy_q;
    logic          err_q;

    logic          beat;
    logic          is_last;
    logic          beat_err;
    logic          halt;
    logic          go;
    logic [AW-1:0] next_addr;
    logic [AW-1:0] wrap_addr;

    // rready_q is only ever high in DATA, so it qualifies the beat alone.
    assign beat     = rvalid_i & rready_q;
    assign is_last  = (count_q == LAST_BEAT);
    assign beat_err = beat & ((rresp_i != 2'b00) | (rlast_i != is_last));

`ifdef RBURST_ERR_HALT_EN
    // Include the error of the beat being accepted right now so an error
    // on the final beat already blocks the back-to-back issue.
    assign halt = err_q | beat_err;
`else
    assign halt = 1'b0;
`endif

    assign go        = en_i & fifo_rdy_i & ~halt;
    assign next_addr = addr_q + BURST_BYTES;
    assign wrap_addr = (next_addr == END_ADDR) ? BASE_ADDR : next_addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= BASE_ADDR;
            count_q   <= 8'd0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (beat_err) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (go) begin
                        state_q   <= ADDR;
                        arvalid_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end else if (!en_i) begin
                        addr_q <= BASE_ADDR;
                    end
                end
                ADDR: begin
                    // arvalid_q stays high until the handshake.
                    if (arready_i) begin
                        state_q   <= DATA;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        count_q   <= 8'd0;
                    end
                end
                DATA: begin
                    if (beat) begin
                        count_q <= count_q + 8'd1;
                        // Burst length is fixed; rlast_i only flags errors.
                        if (is_last) begin
                            addr_q   <= wrap_addr;
                            rready_q <= 1'b0;
                            if (go) begin
                                state_q   <= ADDR;
                                arvalid_q <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_incr_o = beat;
    assign fifo_data_o = rdata_i;
    assign araddr_o    = addr_q;
    assign arlen_o     = LAST_BEAT;
    assign arsize_o    = SIZE_CODE;
    assign arburst_o   = 2'b01;
    assign arvalid_o   = arvalid_q;
    assign rready_o    = rready_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_rburst_master.sv
// Self-checking bench for rburst_master: AXI slave driven from tasks,
// FIFO pushes checked against a scoreboard queue.
module tb_rburst_master;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic        fifo_rdy_i;
    logic        fifo_incr_o;
    logic [63:0] fifo_data_o;
    logic [31:0] araddr_o;
    logic [7:0]  arlen_o;
    logic [2:0]  arsize_o;
    logic [1:0]  arburst_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [63:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rlast_i;
    logic        rvalid_i;
    logic        rready_o;
    logic        busy_o;
    logic        err_o;

    int checks = 0;
    int failures = 0;
    int pushes = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_d;

    rburst_master #(
        .AW(32),
        .DATA_W(64),
        .BURST_LEN(16),
        .BASE_ADDR(32'h1000_0000),
        .FRAME_BYTES(32'd256)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .en_i(en_i),
        .fifo_rdy_i(fifo_rdy_i),
        .fifo_incr_o(fifo_incr_o),
        .fifo_data_o(fifo_data_o),
        .araddr_o(araddr_o),
        .arlen_o(arlen_o),
        .arsize_o(arsize_o),
        .arburst_o(arburst_o),
        .arvalid_o(arvalid_o),
        .arready_i(arready_i),
        .rdata_i(rdata_i),
        .rresp_i(rresp_i),
        .rlast_i(rlast_i),
        .rvalid_i(rvalid_i),
        .rready_o(rready_o),
        .busy_o(busy_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard consumer: every push must match the oldest beat sent.
    always @(negedge clk_i) begin
        if (fifo_incr_o === 1'b1) begin
            pushes++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL fifo_push got=%h exp=none", fifo_data_o);
            end else begin
                exp_d = exp_q.pop_front();
                if (fifo_data_o !== exp_d) begin
                    failures++;
                    $display("FAIL fifo_data got=%h exp=%h",
                             fifo_data_o, exp_d);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_ar(input int hold, input logic [31:0] exp);
        int n = 0;
        while (arvalid_o !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (arvalid_o !== 1'b1) begin
            failures++;
            $display("FAIL ar_timeout got=%b exp=1", arvalid_o);
            return;
        end
        checks++;
        if (araddr_o !== exp || arlen_o !== 8'd15 ||
            arsize_o !== 3'd3 || arburst_o !== 2'b01) begin
            failures++;
            $display("FAIL ar_fields got=%h/%0d/%0d/%0d exp=%h/15/3/1",
                     araddr_o, arlen_o, arsize_o, arburst_o, exp);
        end
        for (int i = 0; i < hold; i++) begin
            step();
            checks++;
            if (arvalid_o !== 1'b1 || araddr_o !== exp) begin
                failures++;
                $display("FAIL ar_hold got=%b/%h exp=1/%h",
                         arvalid_o, araddr_o, exp);
            end
        end
        arready_i = 1'b1;
        step();
        arready_i = 1'b0;
        checks++;
        if (arvalid_o !== 1'b0 || rready_o !== 1'b1) begin
            failures++;
            $display("FAIL ar_handshake got=%b/%b exp=0/1",
                     arvalid_o, rready_o);
        end
    endtask

    task automatic do_r(input int nbeats, input bit gaps,
                        input int resp_beat, input int rlast_beat,
                        input int drop_beat);
        int p0 = pushes;
        for (int i = 0; i < nbeats; i++) begin
            if (gaps) begin
                int g = int'($urandom_range(0, 2));
                for (int k = 0; k < g; k++) begin
                    rvalid_i = 1'b0;
                    @(negedge clk_i);
                    checks++;
                    if (fifo_incr_o !== 1'b0) begin
                        failures++;
                        $display("FAIL gap_incr got=%b exp=0", fifo_incr_o);
                    end
                    step();
                end
            end
            if (i == drop_beat) en_i = 1'b0;
            rvalid_i = 1'b1;
            rdata_i  = {$urandom, $urandom};
            rresp_i  = (i == resp_beat) ? 2'b10 : 2'b00;
            rlast_i  = (i == 15) || (i == rlast_beat);
            exp_q.push_back(rdata_i);
            @(negedge clk_i);
            checks++;
            if (rready_o !== 1'b1) begin
                failures++;
                $display("FAIL rready got=%b exp=1 beat=%0d", rready_o, i);
            end
            step();
            if (i == resp_beat || i == rlast_beat) begin
                checks++;
                if (err_o !== 1'b1) begin
                    failures++;
                    $display("FAIL err_set got=%b exp=1 beat=%0d", err_o, i);
                end
            end
        end
        rvalid_i = 1'b0;
        rlast_i  = 1'b0;
        rresp_i  = 2'b00;
        checks++;
        if (pushes - p0 != nbeats) begin
            failures++;
            $display("FAIL push_count got=%0d exp=%0d", pushes - p0, nbeats);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (arvalid_o !== 1'b0 || rready_o !== 1'b0 ||
            fifo_incr_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl got=%b%b%b%b%b exp=00000",
                     arvalid_o, rready_o, fifo_incr_o, busy_o, err_o);
        end
        checks++;
        if (araddr_o !== BASE) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=%h", araddr_o, BASE);
        end
        checks++;
        if (arlen_o !== 8'd15 || arsize_o !== 3'd3 || arburst_o !== 2'b01) begin
            failures++;
            $display("FAIL reset_const got=%0d/%0d/%0d exp=15/3/1",
                     arlen_o, arsize_o, arburst_o);
        end
        step();
        rst_ni = 1'b1;
    endtask

    task automatic test_basic();
        en_i = 1'b1;
        fifo_rdy_i = 1'b1;
        do_ar(3, BASE);
        do_r(16, 1'b0, -1, -1, -1);
        checks++;
        if (arvalid_o !== 1'b1 || busy_o !== 1'b1 ||
            araddr_o !== BASE + 32'h80) begin
            failures++;
            $display("FAIL back_to_back got=%b/%b/%h exp=1/1/%h",
                     arvalid_o, busy_o, araddr_o, BASE + 32'h80);
        end
        checks++;
        if (err_o !== 1'b0) begin
            failures++;
            $display("FAIL err_clean got=%b exp=0", err_o);
        end
    endtask

    task automatic test_gaps();
        do_ar(0, BASE + 32'h80);
        do_r(16, 1'b1, -1, -1, -1);
    endtask

    task automatic test_wrap_en_drop();
        do_ar(0, BASE);
        do_r(16, 1'b1, -1, -1, 5);
        checks++;
        if (busy_o !== 1'b0 || arvalid_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_drop got=%b/%b exp=0/0",
                     busy_o, arvalid_o);
        end
        step();
        step();
        checks++;
        if (araddr_o !== BASE) begin
            failures++;
            $display("FAIL rewind got=%h exp=%h", araddr_o, BASE);
        end
        en_i = 1'b1;
        fifo_rdy_i = 1'b0;
        step();
        step();
        checks++;
        if (arvalid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL no_room_issue got=%b/%b exp=0/0",
                     arvalid_o, busy_o);
        end
        fifo_rdy_i = 1'b1;
        do_ar(1, BASE);
    endtask

    task automatic test_error();
        bit seen = 1'b0;
        checks++;
        if (err_o !== 1'b0) begin
            failures++;
            $display("FAIL err_pre got=%b exp=0", err_o);
        end
        do_r(16, 1'b0, 2, -1, -1);
`ifdef RBURST_ERR_HALT_EN
        checks++;
        if (busy_o !== 1'b0 || arvalid_o !== 1'b0) begin
            failures++;
            $display("FAIL halt_idle got=%b/%b exp=0/0", busy_o, arvalid_o);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            if (arvalid_o !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL halt_ar got=1 exp=0");
        end
`else
        checks++;
        if (arvalid_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL err_continue got=%b/%b exp=1/1",
                     arvalid_o, busy_o);
        end
        do_ar(0, BASE + 32'h80);
        do_r(16, 1'b0, -1, 9, -1);
        if (arvalid_o !== 1'b1) seen = 1'b1;
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL err_continue2 got=%b exp=1", arvalid_o);
        end
`endif
        checks++;
        if (err_o !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got=%b exp=1", err_o);
        end
    endtask

    task automatic test_reset_mid();
`ifdef RBURST_ERR_HALT_EN
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
`endif
        do_ar(0, BASE);
        do_r(16, 1'b0, -1, -1, -1);
        do_ar(0, BASE + 32'h80);
        do_r(4, 1'b0, -1, -1, -1);
        rst_ni = 1'b0;
        #1;
        checks++;
        if (arvalid_o !== 1'b0 || rready_o !== 1'b0 ||
            fifo_incr_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_ctl got=%b%b%b%b%b exp=00000",
                     arvalid_o, rready_o, fifo_incr_o, busy_o, err_o);
        end
        checks++;
        if (araddr_o !== BASE) begin
            failures++;
            $display("FAIL mid_reset_addr got=%h exp=%h", araddr_o, BASE);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        step();
        rst_ni = 1'b1;
        do_ar(0, BASE);
    endtask

    initial begin
        rst_ni     = 1'b0;
        en_i       = 1'b0;
        fifo_rdy_i = 1'b0;
        arready_i  = 1'b0;
        rdata_i    = '0;
        rresp_i    = 2'b00;
        rlast_i    = 1'b0;
        rvalid_i   = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_wrap_en_drop();
        test_error();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
